// File: rtl/multi_cycle_controller.sv
// Main sequencer for the multi-cycle RV32I core: steps fetch/decode/execute/memory/writeback
// and drives the datapath selects, write enables and ALUOp from the current state.
module multi_cycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] func3,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      LUI      = 4'd12
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Plain vector so that unused codes 13-15 remain representable and recoverable.
   logic [3:0] state_q;
   logic [3:0] state_d;

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:    state_d = MemReady ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECR;
               OP_ITYPE:          state_d = EXECI;
               OP_BRANCH:         state_d = BRANCH;
               OP_JAL:            state_d = JAL;
               OP_JALR:           state_d = JALR;
               OP_LUI:            state_d = LUI;
               default:           state_d = FETCH;
            endcase
         end
         MEMADR:   state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
         EXECR:    state_d = ALUWB;
         EXECI:    state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = FETCH;
         JAL:      state_d = ALUWB;
         JALR:     state_d = JAL;
         LUI:      state_d = FETCH;
         default:  state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   // Outputs follow the state; only FETCH/MEMREAD/MEMWRITE/BRANCH look at MemReady or Zero.
   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = 3'b000;
      ALUOp     = 2'b00;
      RegWrite  = 1'b0;
      State     = state_q;
      if (rst) begin
         // FETCH selects with every write/request enable held off.
         ResultSrc = 2'b10;
         ALUSrcB   = 2'b10;
         State     = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               MemRead   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = MemReady;
               PCWrite   = MemReady;
            end
            DECODE: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
               case (op)
                  OP_STORE:  ImmSrc = 3'b001;
                  OP_BRANCH: ImmSrc = 3'b010;
                  OP_JAL:    ImmSrc = 3'b011;
                  OP_LUI:    ImmSrc = 3'b100;
                  default:   ImmSrc = 3'b000;
               endcase
            end
            MEMADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            MEMREAD: begin
               AdrSrc  = 1'b1;
               MemRead = 1'b1;
            end
            MEMWB: begin
               ResultSrc = 2'b01;
               RegWrite  = 1'b1;
            end
            MEMWRITE: begin
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
            end
            EXECR: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b10;
            end
            EXECI: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ALUOp   = 2'b11;
            end
            ALUWB: begin
               RegWrite = 1'b1;
            end
            BRANCH: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b01;
               ImmSrc  = 3'b010;
               PCWrite = ((func3 == 3'b000) & Zero) | ((func3 == 3'b001) & ~Zero);
            end
            JAL: begin
               // PC loads the target precomputed in ALUOut while the ALU forms OldPC+4.
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               PCWrite = 1'b1;
            end
            JALR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
            end
            LUI: begin
               ResultSrc = 2'b11;
               ImmSrc    = 3'b100;
               RegWrite  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: a driver walks each instruction's state path, pushes
// the expected per-cycle outputs, and a monitor compares them half a cycle later.
module tb_multi_cycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] func3;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0] ImmSrc;
   logic [3:0] State;

   localparam int W = 21;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   logic [6:0] op_tab[9];

   always #5 clk = ~clk;

   multi_cycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .func3(func3), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUOp(ALUOp), .RegWrite(RegWrite), .State(State)
   );

   function automatic logic [W-1:0] pack(input logic [3:0] st, input logic pcw, input logic adr,
                                         input logic mrd, input logic mwr, input logic irw,
                                         input logic [1:0] rs, input logic [1:0] sa,
                                         input logic [1:0] sb, input logic [2:0] imm,
                                         input logic [1:0] aop, input logic rw);
      return {st, pcw, adr, mrd, mwr, irw, rs, sa, sb, imm, aop, rw};
   endfunction

   // Output table for one cycle, written straight from the per-state behaviour list.
   function automatic logic [W-1:0] model(input int st, input bit in_rst, input bit mr,
                                          input bit z, input logic [2:0] f3, input logic [6:0] opc);
      logic [2:0] imm;
      bit taken;
      if (in_rst) return pack(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
      case (st)
         0: return pack(4'd0, mr, 0, 1, 0, mr, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
         1: begin
            imm = (opc == OP_STORE) ? 3'b001 : (opc == OP_BRANCH) ? 3'b010 :
                  (opc == OP_JAL) ? 3'b011 : (opc == OP_LUI) ? 3'b100 : 3'b000;
            return pack(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 2'b00, 0);
         end
         2: return pack(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01,
                        (opc == OP_STORE) ? 3'b001 : 3'b000, 2'b00, 0);
         3: return pack(4'd3, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
         4: return pack(4'd4, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1);
         5: return pack(4'd5, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
         6: return pack(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 0);
         7: return pack(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b11, 0);
         8: return pack(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
         9: begin
            taken = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
            return pack(4'd9, taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b01, 0);
         end
         10: return pack(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00, 0);
         11: return pack(4'd11, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0);
         12: return pack(4'd12, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b100, 2'b00, 1);
         default: return pack(st[3:0], 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
      endcase
   endfunction

   // States visited after DECODE for each instruction class.
   task automatic path_for(input logic [6:0] opc, output int path[$]);
      path = {};
      case (opc)
         OP_LOAD:   path = {2, 3, 4};
         OP_STORE:  path = {2, 5};
         OP_RTYPE:  path = {6, 8};
         OP_ITYPE:  path = {7, 8};
         OP_BRANCH: path = {9};
         OP_JAL:    path = {10, 8};
         OP_JALR:   path = {11, 10, 8};
         OP_LUI:    path = {12};
         default:   path = {};
      endcase
   endtask

   task automatic cycle(input int st, input bit mr, input bit z,
                        input logic [6:0] opc, input logic [2:0] f3);
      @(negedge clk);
      rst = 1'b0; MemReady = mr; Zero = z; op = opc; func3 = f3;
      exp_q.push_back(model(st, 0, mr, z, f3, opc));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b1; MemReady = 1'($urandom); Zero = 1'($urandom);
         exp_q.push_back(model(0, 1, MemReady, Zero, func3, op));
      end
   endtask

   task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input int fwait,
                            input int mwait, input bit zb);
      int path[$];
      path_for(opc, path);
      for (int i = 0; i < fwait; i++) cycle(0, 0, 1'($urandom), opc, f3);
      cycle(0, 1, 1'($urandom), opc, f3);
      cycle(1, 1'($urandom), 1'($urandom), opc, f3);
      foreach (path[k]) begin
         if (path[k] == 3 || path[k] == 5) begin
            for (int i = 0; i < mwait; i++) cycle(path[k], 0, 1'($urandom), opc, f3);
            cycle(path[k], 1, 1'($urandom), opc, f3);
         end else begin
            cycle(path[k], 1'($urandom), (path[k] == 9) ? zb : 1'($urandom), opc, f3);
         end
      end
   endtask

   // Memory access stalled, then reset pulled before MemReady ever arrives.
   task automatic abort_mem(input logic [6:0] opc, input int nrst);
      int st;
      st = (opc == OP_STORE) ? 5 : 3;
      cycle(0, 1, 1'($urandom), opc, 3'd2);
      cycle(1, 1'($urandom), 1'($urandom), opc, 3'd2);
      cycle(2, 1'($urandom), 1'($urandom), opc, 3'd2);
      cycle(st, 0, 1'($urandom), opc, 3'd2);
      cycle(st, 0, 1'($urandom), opc, 3'd2);
      do_reset(nrst);
   endtask

   task automatic force_illegal(input logic [3:0] code);
      @(negedge clk);
      rst = 1'b0; MemReady = 1'($urandom); Zero = 1'($urandom);
      force dut.state_q = code;
      exp_q.push_back(model(int'(code), 0, MemReady, Zero, func3, op));
      #1 release dut.state_q;
   endtask

   initial begin : monitor
      logic [W-1:0] got, exp;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {State, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUOp, RegWrite};
            n_checks++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL cycle_outputs t=%0t state_exp=%0d got=%h exp=%h", $time,
                        exp[W-1 -: 4], got, exp);
            end
         end
      end
   end

   initial begin : driver
      int sel, fw, mw;
      op_tab = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                 OP_JAL, OP_JALR, OP_LUI, 7'b1111111};
      rst = 1'b1; op = 7'd0; func3 = 3'd0; Zero = 1'b0; MemReady = 1'b0;
      do_reset(3);
      run_instr(OP_RTYPE, 3'd0, 0, 0, 0);      // add
      run_instr(OP_LOAD, 3'd2, 0, 2, 0);       // lw, two stall cycles
      run_instr(OP_BRANCH, 3'd0, 0, 0, 1);     // beq taken
      run_instr(OP_BRANCH, 3'd1, 0, 0, 1);     // bne not taken
      run_instr(OP_BRANCH, 3'd4, 0, 0, 0);     // blt never taken here
      run_instr(OP_JALR, 3'd0, 0, 0, 0);
      run_instr(7'b1111111, 3'd0, 0, 0, 0);
      force_illegal(4'd14);
      run_instr(OP_LUI, 3'd0, 2, 0, 0);
      abort_mem(OP_STORE, 2);
      run_instr(OP_STORE, 3'd2, 1, 1, 0);
      abort_mem(OP_LOAD, 1);
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 11);
         fw  = $urandom_range(0, 2);
         mw  = $urandom_range(0, 3);
         if (sel < 9) run_instr(op_tab[sel], 3'($urandom), fw, mw, 1'($urandom));
         else if (sel == 9) run_instr(7'($urandom), 3'($urandom), fw, mw, 1'($urandom));
         else if (sel == 10) force_illegal(4'($urandom_range(13, 15)));
         else abort_mem(($urandom_range(0, 1) == 1) ? OP_STORE : OP_LOAD, $urandom_range(1, 3));
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Main sequencer for the multi-cycle RV32I core. It decodes the opcode latched in the instruction register and steps a Moore state machine through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath's mux selects, register and memory write enables, and the 2-bit ALUOp consumed by the ALU controller. It also stalls on a memory-ready handshake.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  instruction opcode (Instr[6:0])
- func3  in  3  Instr[14:12]
- Zero  in  1  ALU zero flag, combinational from current ALU result
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  latch instruction and OldPC
- ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALUResult, 11=ImmExt
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- ALUOp  out  2  00=add (S_T), 01=sub (B_T), 10=R-type, 11=I-type
- RegWrite  out  1  register file write enable
- State  out  4  current state, for debug and verification

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12. Codes 13–15 are illegal and go to FETCH.
- Outputs are decoded from state only, except the MemReady and Zero qualifiers below. Any output not listed for a state is 0.
- FETCH: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Go to DECODE if MemReady, else stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc selected by op. This precomputes OldPC+imm into ALUOut.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - any other op → FETCH, with no side effects
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=000 for loads or 001 for stores. Next: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: AdrSrc=1, ResultSrc=00, MemRead=1. Hold until MemReady, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held high until MemReady. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=11, ImmSrc=000. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, ImmSrc=010. Next: FETCH.
  - PCWrite = (func3==000 & Zero) | (func3==001 & ~Zero).
  - Any other func3 is not taken.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. PC takes the target held in ALUOut while the ALU computes OldPC+4. Next: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=000. ALUOut becomes rs1+imm. Next: JAL, reused.
- LUI: ResultSrc=11, ImmSrc=100, RegWrite=1. Next: FETCH.

## Timing
- rst sampled high at a clock edge sets State=FETCH.
- While rst is high, PCWrite, IRWrite, RegWrite, MemWrite and MemRead are forced to 0. All other outputs take their FETCH values.
- Reset mid-operation, including while waiting for MemReady in MEMREAD or MEMWRITE, aborts the instruction. No writeback occurs and the machine restarts at FETCH.
- Cycles per instruction with MemReady tied to 1:
  - lui: 3
  - branch: 3
  - R-type, I-type, sw, jal: 4
  - lw, jalr: 5
- Each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. In those waiting cycles no enable other than MemRead or MemWrite is asserted.
- MemReady is ignored in every other state.
- PCWrite, RegWrite and MemWrite take effect at the clock edge that ends the state driving them.

## Test plan
- add (op=0110011, func3=000), MemReady=1: State goes 0→1→6→8→0. ALUOp=10 in EXECR, RegWrite=1 only in ALUWB, 4 cycles total.
- lw with MemReady low for 2 cycles in MEMREAD: State goes 0→1→2→3→3→3→4→0. MemRead=1 for all three MEMREAD cycles and RegWrite=0 until MEMWB.
- beq with Zero=1 gives PCWrite=1 in BRANCH. bne with Zero=1 gives PCWrite=0. blt (func3=100) with Zero=0 gives PCWrite=0. ALUOp=01 in all three cases.
- jalr: State goes 0→1→11→10→8→0. PCWrite=1 only in FETCH and JAL; RegWrite=1 only in ALUWB.
- op=1111111: State goes 0→1→0 with no RegWrite, MemWrite or extra PCWrite. Forcing an illegal state code (14) returns to 0 on the next cycle.
- rst asserted during MEMWRITE with MemReady=0: State=0 on the next cycle and MemWrite stays 0 while rst is high.
